// File: rtl/adder_pkg.sv
// Shared definitions for the serial add/subtract family: default width and FSM state encoding.
package adder_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // Encoding 2'd3 is unused and is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor16.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock, done pulse on completion.
module serial_subtractor16
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             brw_next;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (brw_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new start exactly like IDLE for back-to-back operation.
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    brw    <= brw_next;
                    if (cnt == CNT_LAST) begin
                        diff  <= {d_bit, res_sr[WIDTH-1:1]};
                        bout  <= brw_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed bench for serial_subtractor16 with a cycle-level reference model and literal result checks.
module tb_serial_subtractor16;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: an accepted operation finishes W edges later; result from plain arithmetic.
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic         exp_bout = 1'b0;
    logic         p_bout   = 1'b0;
    logic [W-1:0] exp_diff = '0;
    logic [W-1:0] p_diff   = '0;
    int           rem      = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_diff <= '0;
            exp_bout <= 1'b0;
            rem      <= 0;
        end else if (start && !exp_busy) begin
            p_diff   <= a - b - W'(bin);
            p_bout   <= ({1'b0, a} < ({1'b0, b} + (W+1)'(bin)));
            rem      <= W;
            exp_busy <= 1'b1;
            exp_done <= 1'b0;
        end else if (rem == 1) begin
            rem      <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b1;
            exp_diff <= p_diff;
            exp_bout <= p_bout;
        end else begin
            exp_done <= 1'b0;
            if (rem > 0) rem <= rem - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy", 32'(busy), 32'(exp_busy));
            check("cyc_done", 32'(done), 32'(exp_done));
            check("cyc_diff", 32'(diff), 32'(exp_diff));
            check("cyc_bout", 32'(bout), 32'(exp_bout));
        end
    end

    // Launch one operation; optionally pulse a stray start with other operands at cycle inject_at.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input logic [W-1:0] ediff, input logic ebout, input string name,
                          input int inject_at, output int nbusy);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 40) begin
            if (lat == inject_at) begin
                start = 1'b1;
                a     = 16'h1234;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end
        start = 1'b0;
        if (!done) begin
            check({name, "_timeout"}, 32'(0), 32'(1));
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(16));
            check({name, "_diff"}, 32'(diff), 32'(ediff));
            check({name, "_bout"}, 32'(bout), 32'(ebout));
        end
    endtask

    initial begin
        int nb;
        int lat;
        int nd;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
        rst_n = 1'b1;

        run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "zero", -1, nb);
        check("zero_busy_cycles", 32'(nb), 32'(16));
        run_op(16'h6000, 16'h4000, 1'b0, 16'h2000, 1'b0, "simple", -1, nb);
        run_op(16'h602C, 16'h639C, 1'b1, 16'hFC8F, 1'b1, "negative", -1, nb);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "allones", -1, nb);

        run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, "restart", 5, nb);
        repeat (10) @(negedge clk);
        check("hold_diff", 32'(diff), 32'(16'h0002));
        check("hold_bout", 32'(bout), 32'(0));
        check("hold_done", 32'(done), 32'(0));

        // Back-to-back: start stays high through the first done cycle.
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h1000; b = 16'h0001;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_latency", 32'(lat), 32'(16));
        check("b2b_first_diff", 32'(diff), 32'(16'hFF00));
        check("b2b_first_bout", 32'(bout), 32'(1));
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_gap", 32'(lat), 32'(17));
        check("b2b_second_diff", 32'(diff), 32'(16'h0FFF));
        check("b2b_second_bout", 32'(bout), 32'(0));

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_diff", 32'(diff), 32'(0));
        check("midrst_bout", 32'(bout), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("midrst_no_done", 32'(nd), 32'(0));
        run_op(16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, "after_rst", -1, nb);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor16.md
# serial_subtractor16

Bit-serial 16-bit subtractor computing diff = A − B − Bin, LSB first, one bit per clock. It is the inverse-operation partner to the 16-bit ripple adder, sized for area-constrained datapaths where the result is not needed in the same cycle. The block accepts an operand pair on a single-cycle start and reports the result with a one-cycle done pulse. The result is held stable until the next operation completes.

## Interface

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle onward.
- diff  output  WIDTH  result register, A − B − Bin mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff A < B + Bin, unsigned.

## Operation

- FSM states are IDLE, SHIFT and DONE.
- **IDLE:** start=1 captures a, b and bin into working shift registers and the borrow flop. It also clears bit counter cnt and moves the FSM to SHIFT.
- **SHIFT:** each cycle, the full-subtractor cell works on bit i using a_sr[0], b_sr[0] and brw.
  - d = a^b^brw.
  - brw_next = (~a & b) | (~(a^b) & brw).
  - d shifts into the MSB of the result shift register. a_sr and b_sr shift right.
  - cnt increments each cycle.
  - When cnt = WIDTH−1 in the same cycle: copy the result shift register (including the final d) into diff, copy brw_next into bout, and go to DONE.
- **DONE:** done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE and goes to SHIFT (back-to-back operation). Otherwise the FSM goes to IDLE.
- Other states:
  - start is ignored in SHIFT. Operands presented then are dropped and no queuing occurs.
  - a, b and bin are don't-care except in the accepting cycle.
- diff and bout change only on the completion edge. They hold their value through subsequent IDLE and SHIFT cycles.
- Arithmetic is unsigned, modulo 2^WIDTH. The counter is $clog2(WIDTH) bits and never wraps within an operation.

## Timing

- **Reset values (asynchronous, immediate):** state=IDLE, busy=0, done=0, diff=0, bout=0, cnt=0, and working registers 0.
- **Latency:** start accepted at edge k gives busy=1 from edge k through edge k+WIDTH−1, and done=1 between edges k+WIDTH and k+WIDTH+1.
  - With WIDTH=16, done arrives 16 cycles after the start edge.
- **Throughput:** one result per WIDTH+1 cycles with start held high, because each operation spends one cycle in DONE.
- busy is 0 in IDLE and DONE, and 1 in SHIFT.
- **Reset mid-operation:** the operation is aborted and no done pulse is produced. After release, the first start behaves as from power-up.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure

- Shared package adder_pkg holds:
  - the WIDTH default (16);
  - the state typedef/localparams IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - the encoding 2'd3, which is illegal and recovers to IDLE.
- Sub-module full_subtractor is a combinational 1-bit cell with inputs a, b, bin and outputs d, bout.
  - It is instantiated once inside serial_subtractor16.
  - It is reusable by a future ripple subtractor.

## Test plan

- **Zero operands:** reset, then start with a=0x0000, b=0x0000, bin=0 → done 16 cycles later, diff=0x0000, bout=0. busy=1 for exactly 16 cycles.
- **Simple difference:** a=0x6000, b=0x4000, bin=0 → diff=0x2000, bout=0.
- **Negative result:** a=0x602C, b=0x639C, bin=1 → diff=0xFC8F, bout=1.
- **All-ones with borrow-in:** a=0xFFFF, b=0xFFFF, bin=1 → diff=0xFFFF, bout=1.
- **Restart, hold and back-to-back:**
  - Start a=0x0005, b=0x0003. Pulse start again at cycle 5 with a=0x1234 → ignored; result diff=0x0002.
  - Results stay stable across 10 idle cycles.
  - start held high through the done cycle → second op accepted, done again 17 cycles after the first done.
- **Reset mid-operation:** assert rst_n=0 at cycle 8 of an operation → busy, done, diff and bout are 0 immediately. No done pulse follows. The next op a=0x0001, b=0x0002 → diff=0xFFFF, bout=1.
